// File: rtl/histogram_engine.sv
// Luma histogram with ping-pong bin banks: one bank accumulates the current frame while
// the other holds the last completed frame for random-access readout.
module histogram_engine #(
    parameter int PIX_W = 8,
    parameter int BIN_W = 8,
    parameter int CNT_W = 16,
    parameter int TOT_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [PIX_W-1:0] in_pixel,
    input  logic             in_valid,
    input  logic             end_of_frame,
    input  logic [BIN_W-1:0] rd_addr,
    output logic [CNT_W-1:0] rd_data,
    output logic             rd_valid,
    output logic             frame_done,
    output logic [TOT_W-1:0] pixel_total,
    output logic             busy,
    output logic             overrun
);
    localparam int                 BINS     = 2**BIN_W;
    localparam logic [CNT_W-1:0]   CNT_MAX  = '1;
    localparam logic [TOT_W-1:0]   TOT_MAX  = '1;
    localparam logic [BIN_W-1:0]   BIN_LAST = '1;

    typedef enum logic [1:0] {S_CLEAR, S_ACCUM, S_FLUSH} state_t;

    state_t             r_state;
    logic               r_acc_bank;
    logic [BIN_W-1:0]   r_clr_addr;
    logic               r_flush_cnt;
    logic               r_eof_d;
    logic               r_busy;
    logic               r_rd_valid;
    logic               r_frame_done;
    logic               r_overrun;
    logic               r_rd_gate;
    logic [TOT_W-1:0]   r_total;
    logic [TOT_W-1:0]   r_pixel_total;

    logic               r_s1_valid;
    logic [BIN_W-1:0]   r_s1_bin;
    logic               r_s2_valid;
    logic [BIN_W-1:0]   r_s2_bin;
    logic [CNT_W-1:0]   r_s2_cnt;
    logic               r_s3_valid;
    logic [BIN_W-1:0]   r_s3_bin;
    logic [CNT_W-1:0]   r_s3_cnt;

    logic [CNT_W-1:0]   r_mem [0:2*BINS-1];
    logic [CNT_W-1:0]   r_acc_q;
    logic [CNT_W-1:0]   r_rd_q;
    logic               r_rd_byp;
    logic [CNT_W-1:0]   r_rd_byp_data;

    logic               w_eof_rise;
    logic               w_pix_req;
    logic               w_accum;
    logic               w_accept;
    logic               w_swap;
    logic [BIN_W-1:0]   w_pix_bin;
    logic [CNT_W-1:0]   w_base;
    logic [CNT_W-1:0]   w_inc;
    logic               w_clearing;
    logic               w_wr_en;
    logic [BIN_W:0]     w_wr_addr;
    logic [CNT_W-1:0]   w_wr_data;
    logic               w_rd_bank;
    logic [BIN_W:0]     w_rd_full;

    assign w_eof_rise = end_of_frame & ~r_eof_d;
    assign w_pix_req  = in_valid & en;
    assign w_accum    = (r_state == S_ACCUM);
    assign w_accept   = w_pix_req & w_accum;
    assign w_swap     = (r_state == S_FLUSH) & r_flush_cnt;
    assign w_pix_bin  = in_pixel[PIX_W-1 -: BIN_W];
    assign w_clearing = (r_state == S_CLEAR);

    // Newest in-flight count wins: s2 is about to be written, s3 was written while RAM read the old value.
    assign w_base = (r_s2_valid && r_s2_bin == r_s1_bin) ? r_s2_cnt :
                    (r_s3_valid && r_s3_bin == r_s1_bin) ? r_s3_cnt : r_acc_q;
    assign w_inc  = (w_base == CNT_MAX) ? w_base : w_base + 1'b1;

    assign w_wr_en   = w_clearing | r_s2_valid;
    assign w_wr_addr = w_clearing ? {r_acc_bank, r_clr_addr} : {r_acc_bank, r_s2_bin};
    assign w_wr_data = w_clearing ? '0 : r_s2_cnt;

    // In the swap cycle the bank about to become ready is still the accumulation bank.
    assign w_rd_bank = w_swap ? r_acc_bank : ~r_acc_bank;
    assign w_rd_full = {w_rd_bank, rd_addr};

    always_ff @(posedge clk) begin
        if (w_wr_en)
            r_mem[w_wr_addr] <= w_wr_data;
        r_acc_q       <= r_mem[{r_acc_bank, w_pix_bin}];
        r_rd_q        <= r_mem[w_rd_full];
        r_rd_byp      <= w_wr_en && (w_wr_addr == w_rd_full);
        r_rd_byp_data <= w_wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_CLEAR;
            r_acc_bank    <= 1'b0;
            r_clr_addr    <= '0;
            r_flush_cnt   <= 1'b0;
            r_eof_d       <= 1'b0;
            r_busy        <= 1'b1;
            r_rd_valid    <= 1'b0;
            r_frame_done  <= 1'b0;
            r_overrun     <= 1'b0;
            r_rd_gate     <= 1'b0;
            r_total       <= '0;
            r_pixel_total <= '0;
            r_s1_valid    <= 1'b0;
            r_s1_bin      <= '0;
            r_s2_valid    <= 1'b0;
            r_s2_bin      <= '0;
            r_s2_cnt      <= '0;
            r_s3_valid    <= 1'b0;
            r_s3_bin      <= '0;
            r_s3_cnt      <= '0;
        end else begin
            r_eof_d      <= end_of_frame;
            r_frame_done <= 1'b0;
            r_rd_gate    <= r_rd_valid | w_swap;
            r_overrun    <= r_overrun | (~w_accum & (w_pix_req | w_eof_rise));

            r_s1_valid <= w_accept;
            r_s1_bin   <= w_pix_bin;
            r_s2_valid <= r_s1_valid;
            r_s2_bin   <= r_s1_bin;
            r_s2_cnt   <= w_inc;
            r_s3_valid <= r_s2_valid;
            r_s3_bin   <= r_s2_bin;
            r_s3_cnt   <= r_s2_cnt;

            if (w_accept && r_total != TOT_MAX)
                r_total <= r_total + 1'b1;

            case (r_state)
                S_CLEAR: begin
                    r_clr_addr <= r_clr_addr + 1'b1;
                    if (r_clr_addr == BIN_LAST) begin
                        r_state <= S_ACCUM;
                        r_busy  <= 1'b0;
                    end
                end
                S_ACCUM: begin
                    if (w_eof_rise) begin
                        r_state     <= S_FLUSH;
                        r_busy      <= 1'b1;
                        r_flush_cnt <= 1'b0;
                    end
                end
                S_FLUSH: begin
                    r_flush_cnt <= 1'b1;
                    if (r_flush_cnt) begin
                        r_acc_bank    <= ~r_acc_bank;
                        r_frame_done  <= 1'b1;
                        r_pixel_total <= r_total;
                        r_total       <= '0;
                        r_rd_valid    <= 1'b1;
                        r_clr_addr    <= '0;
                        r_state       <= S_CLEAR;
                    end
                end
                default: begin
                    r_state <= S_CLEAR;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    assign rd_data     = r_rd_gate ? (r_rd_byp ? r_rd_byp_data : r_rd_q) : '0;
    assign rd_valid    = r_rd_valid;
    assign frame_done  = r_frame_done;
    assign pixel_total = r_pixel_total;
    assign busy        = r_busy;
    assign overrun     = r_overrun;
endmodule

// File: tb/tb_histogram_engine.sv
// Bench for histogram_engine: bin model plus a readout scoreboard, frame-by-frame scenarios.
module tb_histogram_engine;
    localparam int PIX_W = 8;
    localparam int BIN_W = 8;
    localparam int CNT_W = 8;
    localparam int TOT_W = 24;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic [PIX_W-1:0] in_pixel = '0;
    logic             in_valid = 1'b0;
    logic             end_of_frame = 1'b0;
    logic [BIN_W-1:0] rd_addr = '0;
    logic [CNT_W-1:0] rd_data;
    logic             rd_valid;
    logic             frame_done;
    logic [TOT_W-1:0] pixel_total;
    logic             busy;
    logic             overrun;

    histogram_engine #(.PIX_W(PIX_W), .BIN_W(BIN_W), .CNT_W(CNT_W), .TOT_W(TOT_W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .in_pixel(in_pixel), .in_valid(in_valid),
        .end_of_frame(end_of_frame), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .frame_done(frame_done), .pixel_total(pixel_total), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct { int addr; int val; } rd_exp_t;
    rd_exp_t sb_q[$];
    logic    rd_issue = 1'b0;

    int n_tests = 0;
    int n_fail = 0;
    int acc_m[256];
    int rdy_m[256];
    int tot_m = 0;
    int rdy_tot_m = 0;
    bit rdy_valid_m = 0;
    int fd_expected = 0;
    int fd_seen = 0;
    int cyc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        rd_exp_t e;
        if (rd_issue) begin
            #1;
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk($sformatf("rd_data[%0d]", e.addr), rd_data, e.val);
            end
        end
    end

    always @(negedge clk) if (rst_n && frame_done) fd_seen++;

    task automatic push_rd(input int a);
        rd_exp_t e;
        rd_addr  = a[7:0];
        rd_issue = 1'b1;
        e.addr = a;
        e.val  = rdy_valid_m ? rdy_m[a] : 0;
        sb_q.push_back(e);
    endtask

    task automatic model_pix(input int p);
        if (acc_m[p] < 255) acc_m[p]++;
        tot_m++;
    endtask

    task automatic pix(input int p, input bit e, input bit rd, input int ra);
        in_pixel = p[7:0];
        in_valid = 1'b1;
        en       = e;
        if (rd) push_rd(ra);
        else rd_issue = 1'b0;
        if (e) model_pix(p);
        tick;
        in_valid = 1'b0;
        rd_issue = 1'b0;
    endtask

    task automatic readall;
        for (int a = 0; a < 256; a++) begin
            push_rd(a);
            tick;
        end
        rd_issue = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 400) begin
            push_rd(n % 256);
            tick;
            n++;
        end
        rd_issue = 1'b0;
        if (busy) chk("idle_timeout", busy, 0);
    endtask

    // Rising vsync, two flush cycles, swap; reads of bin a run across all three cycles.
    task automatic frame_end(input int a, input bit with_pix, input int p);
        rd_exp_t e;
        end_of_frame = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid = (with_pix && k < 2);
            in_pixel = p[7:0];
            en       = 1'b1;
            if (with_pix && k == 0) model_pix(p);
            rd_addr  = a[7:0];
            rd_issue = 1'b1;
            e.addr = a;
            e.val  = (k < 2) ? (rdy_valid_m ? rdy_m[a] : 0) : acc_m[a];
            sb_q.push_back(e);
            tick;
            if (k == 0) begin
                end_of_frame = 1'b0;
                chk("busy_flush", busy, 1);
            end
            if (k < 2) chk("fd_early", frame_done, 0);
            else chk("fd_pulse", frame_done, 1);
        end
        in_valid = 1'b0;
        rd_issue = 1'b0;
        for (int i = 0; i < 256; i++) begin
            rdy_m[i] = acc_m[i];
            acc_m[i] = 0;
        end
        rdy_tot_m   = tot_m;
        tot_m       = 0;
        rdy_valid_m = 1;
        fd_expected++;
        chk("pixel_total", pixel_total, rdy_tot_m);
        chk("rd_valid", rd_valid, 1);
        tick;
        chk("fd_single", frame_done, 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            acc_m[i] = 0;
            rdy_m[i] = 0;
        end
        repeat (3) tick;
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_pixel_total", pixel_total, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_busy", busy, 1);
        rst_n = 1'b1;
        wait_idle(cyc);
        chk("clear_cycles", cyc, 256);

        // Frame 1: every bin exactly once
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                pix(r * 16 + c, 1, 0, 0);
        frame_end(8'h37, 0, 0);
        readall;
        wait_idle(cyc);

        // Frame 2: saturation of a single bin, reads return frame 1
        for (int i = 0; i < 300; i++) pix(8'h2A, 1, 1, i % 256);
        frame_end(8'h2A, 0, 0);
        readall;
        wait_idle(cyc);

        // Frame 3: 5/5/7 forwarding pattern, plus pixels with en low
        for (int i = 0; i < 30; i++) begin
            pix((i % 3 == 2) ? 7 : 5, 1, 1, i);
            if (i % 6 == 0) pix(8'h09, 0, 0, 0);
        end
        frame_end(5, 0, 0);
        readall;
        chk("overrun_clean", overrun, 0);
        wait_idle(cyc);

        // Frame 4: only 0xFF; reads during the frame see frame 3
        for (int i = 0; i < 10; i++) pix(8'hFF, 1, 1, (i < 5) ? 5 : 7);
        frame_end(8'hFF, 0, 0);
        readall;
        wait_idle(cyc);
        chk("overrun_pre", overrun, 0);

        // Frame 5: pixel on the rise cycle counts, pixel one cycle later is dropped
        for (int i = 0; i < 4; i++) pix(8'h10, 1, 1, 8'hFF);
        frame_end(8'h10, 1, 8'h10);
        chk("overrun_pix", overrun, 1);
        end_of_frame = 1'b1;
        tick;
        end_of_frame = 1'b0;
        tick;
        chk("overrun_vs_clear", overrun, 1);
        wait_idle(cyc);
        for (int i = 0; i < 4; i++) pix(8'h33, 1, 1, 8'h10);
        frame_end(8'h33, 0, 0);
        readall;
        wait_idle(cyc);

        // Reset in the middle of a frame
        for (int i = 0; i < 5; i++) pix(8'h44, 1, 1, 8'h33);
        rst_n = 1'b0;
        tick;
        chk("mid_rst_rd_valid", rd_valid, 0);
        chk("mid_rst_rd_data", rd_data, 0);
        chk("mid_rst_busy", busy, 1);
        chk("mid_rst_overrun", overrun, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 256; i++) acc_m[i] = 0;
        tot_m       = 0;
        rdy_valid_m = 0;
        wait_idle(cyc);
        chk("mid_rst_clear_cycles", cyc, 256);
        for (int i = 0; i < 3; i++) pix(8'h44, 1, 1, 8'h44);
        frame_end(8'h44, 0, 0);
        readall;

        repeat (3) tick;
        chk("frame_done_count", fd_seen, fd_expected);
        chk("sb_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
